// File: rtl/alu_shift_pkg.sv
// Shared definitions for the sequential shift unit: opcodes, FSM states, opcode check.
// Pure declarations; no latency or handshake of its own.
package alu_shift_pkg;

   localparam logic [2:0] OP_SLL = 3'b000;
   localparam logic [2:0] OP_SRL = 3'b001;
   localparam logic [2:0] OP_SRA = 3'b010;
   localparam logic [2:0] OP_ROL = 3'b011;
   localparam logic [2:0] OP_ROR = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   function automatic logic op_legal(input logic [2:0] op);
      return (op <= OP_ROR);
   endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational one-position shifter/rotator; zero latency.
// No handshake: the caller decides when the step result is captured.
module shift_step
   import alu_shift_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] d,
   input  logic [2:0]       op,
   output logic [WIDTH-1:0] d_next,
   output logic             bit_out
);

   always_comb begin
      d_next  = d;
      bit_out = 1'b0;
      case (op)
         OP_SLL: begin
            d_next  = {d[WIDTH-2:0], 1'b0};
            bit_out = d[WIDTH-1];
         end
         OP_SRL: begin
            d_next  = {1'b0, d[WIDTH-1:1]};
            bit_out = d[0];
         end
         OP_SRA: begin
            d_next  = {d[WIDTH-1], d[WIDTH-1:1]};
            bit_out = d[0];
         end
         OP_ROL: begin
            d_next  = {d[WIDTH-2:0], d[WIDTH-1]};
            bit_out = d[WIDTH-1];
         end
         OP_ROR: begin
            d_next  = {d[0], d[WIDTH-1:1]};
            bit_out = d[0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequential shift unit, one bit position per clock; accept-to-out_valid = amt+1 cycles (1 for amt 0 / illegal op).
// Backpressure: result held in DONE until out_ready; in_ready low while busy. SHIFT_SEQ_FLAGS_EN adds out_zero/out_neg.
module shift_seq_ctrl
   import alu_shift_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [AMT_W-1:0] in_amt,
   input  logic [2:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_carry,
   output logic             out_err
`ifdef SHIFT_SEQ_FLAGS_EN
   ,
   output logic             out_zero,
   output logic             out_neg
`endif
);

   localparam logic [AMT_W-1:0] CNT_ONE  = AMT_W'(1);
   localparam logic [AMT_W-1:0] CNT_ZERO = '0;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] work_q;
   logic             carry_q;
   logic             err_q;
   logic [2:0]       op_q;
   logic [AMT_W-1:0] cnt_q;
   logic [WIDTH-1:0] step_d;
   logic             step_bit;
   logic             accept;

   assign accept = in_valid & in_ready;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .d       (work_q),
      .op      (op_q),
      .d_next  (step_d),
      .bit_out (step_bit)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               // amt 0 and illegal ops skip the shift loop entirely
               if (op_legal(in_op) && (in_amt != CNT_ZERO)) state_nxt = ST_SHIFT;
               else                                          state_nxt = ST_DONE;
            end
         end
         ST_SHIFT: begin
            if (cnt_q == CNT_ONE) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         work_q  <= '0;
         carry_q <= 1'b0;
         err_q   <= 1'b0;
         op_q    <= OP_SLL;
         cnt_q   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  work_q  <= in_data;
                  carry_q <= 1'b0;
                  err_q   <= ~op_legal(in_op);
                  op_q    <= in_op;
                  cnt_q   <= in_amt;
               end
            end
            ST_SHIFT: begin
               work_q  <= step_d;
               carry_q <= step_bit;
               cnt_q   <= cnt_q - CNT_ONE;
            end
            default: ;
         endcase
      end
   end

   assign out_data  = work_q;
   assign out_carry = carry_q;
   assign out_err   = err_q;

`ifdef SHIFT_SEQ_FLAGS_EN
   logic zero_q, neg_q;

   // Flags track work_q edge-for-edge so they stay aligned with out_data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
      end else if (state == ST_IDLE && accept) begin
         zero_q <= (in_data == '0);
         neg_q  <= in_data[WIDTH-1];
      end else if (state == ST_SHIFT) begin
         zero_q <= (step_d == '0);
         neg_q  <= step_d[WIDTH-1];
      end
   end

   assign out_zero = zero_q;
   assign out_neg  = neg_q;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed vector table, reset/backpressure sequences, random ops vs. model.
module tb_shift_seq_ctrl;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic [2:0]   in_amt = '0;
   logic [2:0]   in_op = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_data;
   logic         out_carry;
   logic         out_err;
`ifdef SHIFT_SEQ_FLAGS_EN
   logic         out_zero;
   logic         out_neg;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   shift_seq_ctrl #(.WIDTH(W), .AMT_W(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_carry (out_carry),
      .out_err   (out_err)
`ifdef SHIFT_SEQ_FLAGS_EN
      ,
      .out_zero  (out_zero),
      .out_neg   (out_neg)
`endif
   );

   typedef struct {
      logic [3:0] d;
      int         amt;
      logic [2:0] op;
      logic [3:0] r;
      logic       c;
      logic       e;
      int         lat;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: whole-operation result from shift arithmetic, not bit-by-bit stepping.
   function automatic void model(input logic [3:0] d, input int amt, input logic [2:0] op,
                                 output logic [3:0] r, output logic c, output logic e);
      logic [15:0] wide;
      logic [7:0]  dd;
      int          v, k;
      r = d; c = 1'b0; e = 1'b0;
      k = amt % W;
      dd = {d, d};
      case (op)
         3'b000: begin
            wide = 16'(d) << amt;
            r = wide[3:0];
            c = (amt == 0 || amt > W) ? 1'b0 : d[W-amt];
         end
         3'b001: begin
            r = (amt >= W) ? 4'b0 : (d >> amt);
            c = (amt == 0 || amt > W) ? 1'b0 : d[amt-1];
         end
         3'b010: begin
            v = d[3] ? int'(d) - 16 : int'(d);
            v = v >>> amt;
            r = v[3:0];
            c = (amt == 0) ? 1'b0 : (amt <= W) ? d[amt-1] : d[W-1];
         end
         3'b011: begin
            dd = dd << k;
            r = dd[7:4];
            c = (amt == 0) ? 1'b0 : r[0];
         end
         3'b100: begin
            dd = dd >> k;
            r = dd[3:0];
            c = (amt == 0) ? 1'b0 : r[W-1];
         end
         default: e = 1'b1;
      endcase
   endfunction

   // Starts and ends just after a falling edge.
   task automatic do_op(input logic [3:0] d, input int amt, input logic [2:0] op,
                        input logic [3:0] er, input logic ec, input logic ee,
                        input int elat, input int stall, input string nm);
      int lat;
      chk({nm, " in_ready idle"}, 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_data = d; in_amt = amt[2:0]; in_op = op;
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = 4'($urandom); in_amt = 3'($urandom); in_op = 3'($urandom);
      lat = 1;
      @(negedge clk);
      while (!out_valid && lat < 40) begin
         lat++;
         @(negedge clk);
      end
      if (elat >= 0) chk({nm, " latency"}, 32'(lat), 32'(elat));
      chk({nm, " out_valid"}, 32'(out_valid), 32'd1);
      chk({nm, " data"},  32'(out_data),  32'(er));
      chk({nm, " carry"}, 32'(out_carry), 32'(ec));
      chk({nm, " err"},   32'(out_err),   32'(ee));
`ifdef SHIFT_SEQ_FLAGS_EN
      chk({nm, " zero"}, 32'(out_zero), 32'(er == 4'b0));
      chk({nm, " neg"},  32'(out_neg),  32'(er[3]));
`endif
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1; in_data = ~d; in_amt = 3'd1; in_op = 3'b000;
         @(negedge clk);
         chk({nm, " hold valid"}, 32'(out_valid), 32'd1);
         chk({nm, " hold data"},  32'(out_data),  32'(er));
         chk({nm, " hold carry"}, 32'(out_carry), 32'(ec));
         chk({nm, " hold ready"}, 32'(in_ready),  32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk({nm, " valid drop"}, 32'(out_valid), 32'd0);
      chk({nm, " ready back"}, 32'(in_ready),  32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[13];
      logic [3:0] mr;
      logic       mc, me;
      int         amt;
      logic [3:0] d;
      logic [2:0] op;

      vecs[0]  = '{4'b1011, 1, 3'b000, 4'b0110, 1'b1, 1'b0, 2};
      vecs[1]  = '{4'b1000, 2, 3'b010, 4'b1110, 1'b0, 1'b0, 3};
      vecs[2]  = '{4'b0011, 1, 3'b100, 4'b1001, 1'b1, 1'b0, 2};
      vecs[3]  = '{4'b1001, 4, 3'b011, 4'b1001, 1'b1, 1'b0, 5};
      vecs[4]  = '{4'b1111, 7, 3'b001, 4'b0000, 1'b0, 1'b0, 8};
      vecs[5]  = '{4'b0101, 0, 3'b000, 4'b0101, 1'b0, 1'b0, 1};
      vecs[6]  = '{4'b1100, 3, 3'b111, 4'b1100, 1'b0, 1'b1, 1};
      vecs[7]  = '{4'b1010, 7, 3'b010, 4'b1111, 1'b1, 1'b0, 8};
      vecs[8]  = '{4'b0011, 4, 3'b000, 4'b0000, 1'b1, 1'b0, 5};
      vecs[9]  = '{4'b0011, 5, 3'b000, 4'b0000, 1'b0, 1'b0, 6};
      vecs[10] = '{4'b1000, 6, 3'b100, 4'b0010, 1'b0, 1'b0, 7};
      vecs[11] = '{4'b0110, 2, 3'b001, 4'b0001, 1'b1, 1'b0, 3};
      vecs[12] = '{4'b0000, 0, 3'b101, 4'b0000, 1'b0, 1'b1, 1};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst in_ready",  32'(in_ready),  32'd1);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst out_data",  32'(out_data),  32'd0);
      chk("rst out_carry", 32'(out_carry), 32'd0);
      chk("rst out_err",   32'(out_err),   32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Reset while shifting discards the partial result
      in_valid = 1'b1; in_data = 4'b1011; in_amt = 3'd3; in_op = 3'b000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("midop busy", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midop out_valid", 32'(out_valid), 32'd0);
      chk("midop in_ready",  32'(in_ready),  32'd1);
      chk("midop out_data",  32'(out_data),  32'd0);
      chk("midop out_carry", 32'(out_carry), 32'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("midop stays idle", 32'(out_valid), 32'd0);

      // Directed vectors, checked against hand values and the model
      for (int i = 0; i < 13; i++) begin
         model(vecs[i].d, vecs[i].amt, vecs[i].op, mr, mc, me);
         chk($sformatf("model v%0d data", i), 32'(mr), 32'(vecs[i].r));
         chk($sformatf("model v%0d carry", i), 32'(mc), 32'(vecs[i].c));
         do_op(vecs[i].d, vecs[i].amt, vecs[i].op, vecs[i].r, vecs[i].c, vecs[i].e,
               vecs[i].lat, 0, $sformatf("v%0d", i));
      end

      // Backpressure: 5 stalled cycles with in_valid asserted, then back-to-back ops
      do_op(4'b1100, 2, 3'b001, 4'b0011, 1'b0, 1'b0, 3, 5, "bp srl");
      do_op(4'b0111, 1, 3'b011, 4'b1110, 1'b0, 1'b0, 2, 0, "b2b rol");
      do_op(4'b1001, 3, 3'b010, 4'b1111, 1'b0, 1'b0, 4, 2, "b2b sra");

      // Random operations vs. model with random stalls
      for (int n = 0; n < 60; n++) begin
         d   = 4'($urandom);
         amt = int'($urandom_range(0, 7));
         op  = 3'($urandom_range(0, 7));
         model(d, amt, op, mr, mc, me);
         do_op(d, amt, op, mr, mc, me,
               (me || amt == 0) ? 1 : amt + 1,
               int'($urandom_range(0, 3)), $sformatf("rnd%0d op%0d amt%0d d%h", n, op, amt, d));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
